// File: rtl/pulse_scheduler.sv
// pulse_scheduler: round-robin owner arbitration for one shared pulse_generator.
// A granted requester gets a burst of req_count pulses at a period of req_ticks
// clock ticks; the scheduler loads the generator, counts its output pulses and
// strobes done to the owner when the burst completes.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req             per-requester level request (held until done or withdrawn)
//   req_ticks       packed periods, requester i at [i*N +: N]
//   req_count       packed burst lengths, requester i at [i*C +: C]
//   grant           one-hot current owner, zero when idle
//   done            one-hot, one-cycle burst-complete strobe
//   busy            scheduler not idle
//   pulse_out       generator pulse qualified by the RUN state (combinational)
//   gen_rst/gen_ena/gen_ticks  drive the shared generator
//   gen_out         generator output pulse
module pulse_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned N       = 7,
    parameter int unsigned C       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*N-1:0] req_ticks,
    input  logic [NUM_REQ*C-1:0] req_count,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 busy,
    output logic                 pulse_out,
    output logic                 gen_rst,
    output logic                 gen_ena,
    output logic [N-1:0]         gen_ticks,
    input  logic                 gen_out
);

    localparam int unsigned IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned IW1 = IW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state, state_d;
    logic [IW-1:0]      idx, idx_d;
    logic [IW-1:0]      rr, rr_d;
    logic [C-1:0]       remaining, remaining_d;
    logic [NUM_REQ-1:0] grant_d, done_d;
    logic               busy_d, gen_rst_d, gen_ena_d;
    logic [N-1:0]       gen_ticks_d;

    logic               found;
    logic [IW-1:0]      pick;
    logic [IW1-1:0]     cand;
    logic [IW-1:0]      idx_next;

    // First asserted request at or above the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr} + IW1'(k);
            if (cand >= IW1'(NUM_REQ)) begin
                cand = cand - IW1'(NUM_REQ);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    // Pointer value that gives the current owner lowest priority.
    assign idx_next = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);

    // Next-state logic; registered outputs are derived from the state being entered.
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        rr_d        = rr;
        remaining_d = remaining;
        gen_ticks_d = gen_ticks;

        case (state)
            S_IDLE: begin
                if (found) begin
                    idx_d       = pick;
                    gen_ticks_d = req_ticks[int'(pick) * N +: N];
                    remaining_d = req_count[int'(pick) * C +: C];
                    state_d     = (remaining_d == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (!req[idx]) begin
                    state_d = S_IDLE;
                    rr_d    = idx_next;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Withdrawal wins over a coincident final pulse: no done strobe.
                if (!req[idx]) begin
                    state_d = S_IDLE;
                    rr_d    = idx_next;
                end else if (gen_out) begin
                    remaining_d = remaining - C'(1);
                    if (remaining == C'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rr_d    = idx_next;
            end
        endcase

        grant_d   = (state_d != S_IDLE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_d) : '0;
        done_d    = (state_d == S_DONE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_d) : '0;
        busy_d    = (state_d != S_IDLE);
        gen_ena_d = (state_d == S_RUN);
        gen_rst_d = (state_d != S_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            rr        <= '0;
            remaining <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            gen_rst   <= 1'b1;
            gen_ena   <= 1'b0;
            gen_ticks <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            rr        <= rr_d;
            remaining <= remaining_d;
            grant     <= grant_d;
            done      <= done_d;
            busy      <= busy_d;
            gen_rst   <= gen_rst_d;
            gen_ena   <= gen_ena_d;
            gen_ticks <= gen_ticks_d;
        end
    end

    assign pulse_out = gen_out & (state == S_RUN);

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler with a behavioural pulse_generator:
// after ena rises the generator emits a one-cycle pulse every `ticks` cycles.
module tb_pulse_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned N  = 7;
    localparam int unsigned C  = 8;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*N-1:0] req_ticks;
    logic [NR*C-1:0] req_count;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            busy;
    logic            pulse_out;
    logic            gen_rst;
    logic            gen_ena;
    logic [N-1:0]    gen_ticks;
    logic            gen_out;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int viol  = 0;
    int gcnt  = 0;

    pulse_scheduler #(.NUM_REQ(NR), .N(N), .C(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_ticks (req_ticks),
        .req_count (req_count),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .pulse_out (pulse_out),
        .gen_rst   (gen_rst),
        .gen_ena   (gen_ena),
        .gen_ticks (gen_ticks),
        .gen_out   (gen_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generator model: pulse once every gen_ticks enabled cycles.
    always @(posedge clk) begin
        if (gen_rst) begin
            gcnt    <= 0;
            gen_out <= 1'b0;
        end else if (gen_ena) begin
            if (gcnt + 1 >= int'(gen_ticks)) begin
                gcnt    <= 0;
                gen_out <= 1'b1;
            end else begin
                gcnt    <= gcnt + 1;
                gen_out <= 1'b0;
            end
        end else begin
            gen_out <= 1'b0;
        end
    end

    // Structural properties watched on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (!$onehot0(grant))            viol <= viol + 1;
            if (!$onehot0(done))             viol <= viol + 1;
            if ((done & ~grant) != '0)       viol <= viol + 1;
            if (gen_ena && (grant == '0))    viol <= viol + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int who, input int ticks, input int count);
        req_ticks[who*N +: N] = N'(ticks);
        req_count[who*C +: C] = C'(count);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (grant == '0 && n < 20) begin
            tick();
            n++;
        end
        if (grant == '0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_pulse(input string tag);
        int n = 0;
        tick();
        while (!pulse_out && n < 500) begin
            tick();
            n++;
        end
        if (!pulse_out) check({tag, "_timeout"}, 0, 1);
    endtask

    // Follow one burst to its done strobe, checking spacing and completion.
    task automatic watch_burst(input int who, input int npulse, input int gap, input int new_ticks);
        int  pulses = 0;
        int  last   = -1;
        int  ena_c  = -1;
        bit  fin    = 1'b0;
        if (gen_ena) ena_c = cyc;
        for (int i = 0; i < 2000 && !fin; i++) begin
            tick();
            if (ena_c < 0 && gen_ena) ena_c = cyc;
            if (pulse_out) begin
                if (pulses == 0) check("first_gap", 32'(cyc - ena_c), 32'(gap));
                else             check("pulse_gap", 32'(cyc - last), 32'(gap));
                pulses++;
                last = cyc;
                if (pulses == 1 && new_ticks != 0) req_ticks[who*N +: N] = N'(new_ticks);
            end
            if (done != '0) begin
                check("done_owner", 32'(done), 32'(1 << who));
                check("done_grant", 32'(grant), 32'(1 << who));
                check("pulse_total", 32'(pulses), 32'(npulse));
                check("done_latency", 32'(cyc - last), 32'd1);
                req[who] = 1'b0;
                fin = 1'b1;
            end
        end
        if (!fin) check("burst_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_ticks = '0;
        req_count = '0;

        // Reset values
        do_reset();
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ena", 32'(gen_ena), 0);
        check("rst_genrst", 32'(gen_rst), 1);
        check("rst_ticks", 32'(gen_ticks), 0);
        check("rst_pulse", 32'(pulse_out), 0);

        // Single burst: ticks 120, count 3
        set_req(0, 120, 3);
        req = 4'b0001;
        tick();
        check("s_grant", 32'(grant), 32'b0001);
        check("s_busy", 32'(busy), 1);
        check("s_load_ena", 32'(gen_ena), 0);
        check("s_load_rst", 32'(gen_rst), 1);
        check("s_ticks", 32'(gen_ticks), 120);
        tick();
        check("s_run_ena", 32'(gen_ena), 1);
        check("s_run_rst", 32'(gen_rst), 0);
        watch_burst(0, 3, 120, 0);
        tick();
        check("s_after_grant", 32'(grant), 0);
        check("s_after_ena", 32'(gen_ena), 0);
        check("s_after_busy", 32'(busy), 0);

        // Round-robin over all four requesters
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 10, 2);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_grant("rr");
            check("rr_grant", 32'(grant), 32'(1 << k));
            watch_burst(k, 2, 10, 0);
            tick();
            check("rr_gap", 32'(grant), 0);
        end
        req = 4'b0001;
        wait_grant("rr_again");
        check("rr_again_grant", 32'(grant), 32'b0001);
        watch_burst(0, 2, 10, 0);
        tick();

        // Zero-length burst
        set_req(2, 10, 0);
        req = 4'b0100;
        tick();
        check("z_grant", 32'(grant), 32'b0100);
        check("z_done", 32'(done), 32'b0100);
        check("z_ena", 32'(gen_ena), 0);
        req = '0;
        tick();
        check("z_grant_clr", 32'(grant), 0);
        check("z_done_clr", 32'(done), 0);
        check("z_ena_idle", 32'(gen_ena), 0);

        // Withdrawal after the second pulse, with requester 2 pending
        set_req(1, 20, 5);
        set_req(2, 10, 1);
        req = 4'b0110;
        wait_grant("w");
        check("w_grant", 32'(grant), 32'b0010);
        wait_pulse("w_p1");
        wait_pulse("w_p2");
        req[1] = 1'b0;
        tick();
        check("w_grant_clr", 32'(grant), 0);
        check("w_no_done", 32'(done), 0);
        check("w_ena", 32'(gen_ena), 0);
        tick();
        check("w_next_grant", 32'(grant), 32'b0100);
        watch_burst(2, 1, 10, 0);
        tick();

        // Reset in the middle of a burst
        set_req(3, 10, 3);
        req = 4'b1000;
        wait_grant("m");
        check("m_grant", 32'(grant), 32'b1000);
        wait_pulse("m_p1");
        rst = 1'b1;
        tick();
        check("m_grant_clr", 32'(grant), 0);
        check("m_ena", 32'(gen_ena), 0);
        check("m_genrst", 32'(gen_rst), 1);
        check("m_busy", 32'(busy), 0);
        check("m_no_done", 32'(done), 0);
        rst = 1'b0;
        set_req(1, 10, 1);
        req = 4'b1010;
        tick();
        check("m_restart_grant", 32'(grant), 32'b0010);
        watch_burst(1, 1, 10, 0);
        req = '0;
        tick();

        // Period change during a burst is ignored
        do_reset();
        set_req(0, 120, 3);
        req = 4'b0001;
        wait_grant("st");
        check("st_grant", 32'(grant), 32'b0001);
        watch_burst(0, 3, 120, 30);
        tick();

        check("invariants", 32'(viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
